// File: rtl/exe_div_iter.sv
// Iterative 32-bit DIV/DIVU for the EXE stage: one restoring radix-2 step per cycle,
// stalling the EXE/MEM register until the {HI=remainder, LO=quotient} result is ready.
module exe_div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    input  logic        accept,
    output logic        stall_req,
    output logic        done,
    output logic [63:0] div_result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [63:0] acc, acc_step;
    logic [31:0] dvsr;
    logic        q_neg, r_neg;
    logic        latch_ops, finish;
    logic [31:0] a_abs, b_abs, q_fix, r_fix, sub_lo;
    logic        ge;

    // Handshake: stall_req holds the EXE/MEM register while a divide is accepted
    // or running; done marks a valid result, consumed on a cycle with accept=1.
    always_comb begin
        state_nxt = state;
        latch_ops = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = BUSY;
                latch_ops = 1'b1;
            end
            BUSY: if (count == 5'd31) begin
                state_nxt = DONE;
                finish    = 1'b1;
            end
            DONE: if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            latch_ops = 1'b0;
            finish    = 1'b0;
        end
    end

    assign stall_req = ((state == IDLE) && start && !flush) || (state == BUSY);
    assign done      = (state == DONE);

    assign a_abs = (is_signed && dividend[31]) ? -dividend : dividend;
    assign b_abs = (is_signed && divisor[31])  ? -divisor  : divisor;

    // The shifted partial remainder is 33 bits wide; after a successful subtract it
    // is below the divisor, so the low 32 bits of the difference are exact.
    assign ge       = acc[63:31] >= {1'b0, dvsr};
    assign sub_lo   = acc[62:31] - dvsr;
    assign acc_step = ge ? {sub_lo, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

    assign q_fix = q_neg ? -acc_step[31:0]  : acc_step[31:0];
    assign r_fix = r_neg ? -acc_step[63:32] : acc_step[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 5'd0;
            acc        <= 64'd0;
            dvsr       <= 32'd0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div_result <= 64'd0;
        end else begin
            state <= state_nxt;
            if (latch_ops) begin
                acc   <= {32'd0, a_abs};
                dvsr  <= b_abs;
                // Divide-by-zero keeps LO all ones, so it never takes the quotient sign.
                q_neg <= is_signed && (dividend[31] ^ divisor[31]) && (divisor != 32'd0);
                r_neg <= is_signed && dividend[31];
                count <= 5'd0;
            end else if (state == BUSY) begin
                acc   <= acc_step;
                count <= count + 5'd1;
            end
            if (finish) div_result <= {r_fix, q_fix};
        end
    end

endmodule

// File: doc/exe_div_iter.md
EXE_DIV_ITER -- requirements
Module: exe_div_iter

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  EXE instruction is DIV/DIVU; held high while the instruction sits in EXE.
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start.
- dividend  in  32  rs value, forwarded.
- divisor  in  32  rt value, forwarded.
- flush  in  1  irq/clr cancel for the EXE instruction.
- accept  in  1  EXE/MEM register advances this cycle (not stalled).
- stall_req  out  1  divide in progress; drives the stall into the EXE/MEM register.
- done  out  1  result valid.
- div_result  out  64  {HI = remainder, LO = quotient}; feeds MulDiv_result.

Function
REQ-003 The block SHALL be an FSM with states IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-004 IDLE with start=1 and flush=0 SHALL latch the operands and go to BUSY with count=0.
- Latched operands: |dividend|, |divisor|, quotient sign, remainder sign.
- Absolute values SHALL be taken only when is_signed=1.
REQ-005 BUSY SHALL run one restoring radix-2 step per cycle over a 64-bit remainder/quotient register for 32 cycles (count 0..31), then go to DONE.
REQ-006 On entry to DONE, the quotient SHALL be negated if the quotient sign is 1, and the remainder negated if the remainder sign is 1.
REQ-007 DONE SHALL assert done=1 and present div_result.
- DONE returns to IDLE when accept=1.
- DONE holds, with done and div_result stable, while accept=0.
REQ-008 Latency SHALL be as follows:
- start first sampled in cycle T.
- BUSY for cycles T+1..T+32.
- done=1 from cycle T+33.
REQ-009 stall_req SHALL be (IDLE and start and not flush) or BUSY.
- stall_req SHALL be 0 in DONE.
REQ-010 div_result SHALL hold its last value in IDLE until the next completed divide overwrites it.
REQ-011 A zero divisor SHALL take the full latency and yield LO=0xFFFFFFFF and HI=dividend, for either signedness.
REQ-012 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000 (wrap, no trap).
REQ-013 flush=1 in any state SHALL force IDLE on the next edge.
- done and stall_req SHALL be 0 on that next cycle.
- The result SHALL be discarded and div_result left unchanged.
REQ-014 When flush and start are high in the same IDLE cycle, flush SHALL win: no operand latch, stall_req=0.
REQ-015 Operand changes during BUSY or DONE SHALL be ignored.
REQ-016 start=0 during BUSY SHALL NOT abort the operation; only flush or rst abort.
REQ-017 Reset-to-reset timing SHALL NOT exceed one cycle from any state.

Reset
REQ-018 rst=1 SHALL force the following on the next edge, overriding all other inputs:
- state=IDLE, count=0, div_result=0, done=0.
- stall_req SHALL then be a function of start alone, per REQ-009.
REQ-019 Reset asserted mid-BUSY SHALL abandon the divide, with no done pulse after reset release.

Verification
REQ-020 Unsigned divide: start, is_signed=0, 100/7 at T -> stall_req=1 in T..T+32, done=1 at T+33, LO=14 (0x0000000E), HI=2.
REQ-021 Signed divide: is_signed=1, 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-022 Edge operands:
- Divisor 0, dividend 0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678 at T+33.
- Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-023 Abort and restart: flush=1 at T+10 -> IDLE at T+11, done never asserts, div_result unchanged; a fresh start of 9/3 at T+12 -> done at T+45, LO=3, HI=0.
REQ-024 Hold in DONE: accept=0 for 3 cycles in DONE -> done and div_result stable, stall_req=0; accept=1 -> IDLE next cycle.
REQ-025 Reset mid-operation: rst=1 at T+5 -> all outputs 0 next cycle; no done pulse within 40 cycles with start=0.
